// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A 32-bit (4*NUM_DIGITS) value is captured into a shadow register and
// copied into the display register only when the scan wraps back to digit 0.
// That way every scan frame shows one consistent value. Each digit slot starts
// with a few dead cycles, with all anodes off, so the previous digit's segments
// do not ghost onto the next anode.
//
// Ports:
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset
//   val_in        value to display, digit i = val_in[4i+3:4i]
//   val_valid_in  one-cycle strobe capturing val_in into the shadow register
//   digit_en_in   per-digit enable, 0 blanks that digit
//   blank_lz_in   enables leading-zero blanking (digit 0 is never blanked)
//   hex_out       nibble of the digit currently being scanned (to decoder)
//   seg_in        active-low segment pattern returned by the decoder
//   cat_out       registered active-low cathodes
//   an_out        registered active-low anodes (one-hot-low or all-high)
//   frame_out     one-cycle pulse in the first cycle of each scan frame
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    val_valid_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    blank_lz_in,
  output logic [3:0]              hex_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              cat_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_out
);

  localparam int CW = $clog2(COUNT_PERIOD);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         shadow;
  logic [VW-1:0]         disp;

  logic                  slot_end;
  logic                  frame_end;
  logic                  in_dead;
  logic                  en_cur;
  logic                  upper_zero;
  logic                  zero_acc;
  logic                  blank_cur;
  logic                  off;
  logic [NUM_DIGITS-1:0] sel;

  assign slot_end  = (cnt == CW'(COUNT_PERIOD - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  // The dead window at the start of each slot. With BLANK_CYCLES = 0 there is
  // no window at all, so that case is tied off instead of comparing against 0.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  // Per-digit selection from the current scan index. The loop walks from the
  // most significant digit downwards while accumulating "every nibble so far is
  // zero". When it reaches the current digit, that accumulator tells us
  // whether this digit and everything above it are zero, which is the
  // leading-zero condition. The same pass picks out the nibble, the enable bit
  // and the one-hot anode select. This avoids variable part-selects that could
  // run past the vector when NUM_DIGITS is not a power of two.
  always_comb begin
    sel        = '0;
    hex_out    = 4'h0;
    en_cur     = 1'b0;
    upper_zero = 1'b0;
    zero_acc   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc = zero_acc && (disp[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        sel[i]     = 1'b1;
        hex_out    = disp[4*i +: 4];
        en_cur     = digit_en_in[i];
        upper_zero = zero_acc;
      end
    end
  end

  // A digit goes dark when it is disabled, or when it is a leading zero and
  // leading-zero blanking is on. Digit 0 is excluded from leading-zero
  // blanking so that a value of zero still shows a single "0".
  always_comb begin
    blank_cur = !en_cur || (blank_lz_in && (idx != '0) && upper_zero);
    off       = blank_cur || in_dead;
  end

  // Slot counter and digit index. cnt runs through one digit slot. When it
  // completes a slot, the index advances and wraps after the last digit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Value path. Every strobe lands in the shadow register, and the last strobe
  // in a frame wins. The display register only moves at the frame wrap, so a
  // frame never mixes two values. A strobe on the wrap edge itself goes
  // straight into disp, because the shadow would only hold it one edge too
  // late.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow <= '0;
      disp   <= '0;
    end else begin
      if (val_valid_in) begin
        shadow <= val_in;
      end
      if (frame_end) begin
        disp <= val_valid_in ? val_in : shadow;
      end
    end
  end

  // Registered pin drivers. They lag the scan state by one cycle. The reset is
  // asynchronous, so the display goes dark the moment reset asserts. frame_out
  // is set by the wrap edge, which makes it high exactly in the first cycle of
  // the new frame. That also means the frame starting from reset gets no pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      an_out    <= '1;
      cat_out   <= 7'h7F;
      frame_out <= 1'b0;
    end else begin
      an_out    <= off ? '1 : ~sel;
      cat_out   <= off ? 7'h7F : seg_in;
      frame_out <= frame_end;
    end
  end

endmodule
